// File: rtl/inst_encoder_if.sv
// Field-bundle input and encoded-word output handshake for the RV32I instruction encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [1:0]  out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready,
    input  out_valid, out_inst, out_addr, out_err,
    output out_ready
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready,
    output out_valid, out_inst, out_addr, out_err,
    input  out_ready
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields plus a sign-extended immediate into an instruction word,
// tags it with a sequential write address and error code, and queues it in a small FIFO.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  inst_encoder_if.slave    bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_B = 3'b001;
  localparam logic [2:0] FMT_J = 3'b010;
  localparam logic [2:0] FMT_S = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  typedef logic [AW-1:0] ptr_t;

  // True when v is a sign-extension of its low nbits bits.
  function automatic logic fits_signed(input logic signed [31:0] v, input int nbits);
    logic signed [31:0] t;
    t = v >>> (nbits - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] imm);
    case (fmt)
      FMT_I:   return {imm[11:0], rs1, f3, rd, op};
      FMT_S:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   return {imm[31:12], rd, op};
      FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      FMT_R:   return {f7, rs2, rs1, f3, rd, op};
      default: return NOP;
    endcase
  endfunction

  // Priority: illegal format, then misalignment, then immediate range.
  function automatic logic [1:0] check_err(input logic [2:0] fmt, input logic signed [31:0] imm);
    case (fmt)
      FMT_I, FMT_S: return fits_signed(imm, 12) ? 2'b00 : 2'b01;
      FMT_B:        return imm[0] ? 2'b10 : (fits_signed(imm, 13) ? 2'b00 : 2'b01);
      FMT_J:        return imm[0] ? 2'b10 : (fits_signed(imm, 21) ? 2'b00 : 2'b01);
      FMT_U:        return (imm[11:0] != 12'd0) ? 2'b10 : 2'b00;
      FMT_R:        return 2'b00;
      default:      return 2'b11;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [31:0]       mem_inst [DEPTH];
  logic [31:0]       mem_addr [DEPTH];
  logic [1:0]        mem_err  [DEPTH];
  ptr_t              wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic [31:0]       next_addr;

  logic signed [31:0] imm_p0;
  logic [1:0]         err_p0;
  logic [31:0]        inst_p0;
  logic               vld_p0;
  logic               pop;

  // Stage p0: combinational encode and error classification of the offered bundle.
  assign imm_p0  = bus.in_imm;
  assign err_p0  = check_err(bus.in_fmt, imm_p0);
  assign inst_p0 = (err_p0 != 2'b00) ? NOP
                 : encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                          bus.in_funct3, bus.in_funct7, bus.in_imm);

  assign bus.in_ready = (cnt != FULL_CNT) && !rst && !clr;
  assign vld_p0       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (cnt != '0);
  assign pop           = bus.out_valid && bus.out_ready;

  // Stage p1: FIFO storage; head is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      mem_inst[wr_ptr] <= inst_p0;
      mem_addr[wr_ptr] <= next_addr;
      mem_err[wr_ptr]  <= err_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      next_addr <= BASE_ADDR;
      word_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (vld_p0) begin
        wr_ptr    <= wr_ptr + ptr_t'(1);
        next_addr <= next_addr + 32'd4;
        word_cnt  <= sat_inc(word_cnt);
        if (err_p0 != 2'b00) err_cnt <= sat_inc(err_cnt);
      end
      if (pop) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({vld_p0, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.out_inst = bus.out_valid ? mem_inst[rd_ptr] : 32'd0;
  assign bus.out_addr = bus.out_valid ? mem_addr[rd_ptr] : 32'd0;
  assign bus.out_err  = bus.out_valid ? mem_err[rd_ptr]  : 2'd0;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed and random-legal checks for inst_encoder: encodings, errors, FIFO flow, clr.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [15:0] word_cnt, err_cnt;
  int          tests_run = 0;
  int          tests_failed = 0;

  inst_encoder_if bus();

  inst_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_bundle(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [31:0] imm);
    bus.in_fmt = fmt; bus.in_opcode = op; bus.in_rd = rd; bus.in_rs1 = rs1;
    bus.in_rs2 = rs2; bus.in_funct3 = f3; bus.in_funct7 = 7'd0; bus.in_imm = imm;
  endtask

  // Offers the current bundle, waits for acceptance, returns 1 ns after the accepting edge.
  task automatic send;
    int n;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                             input logic [1:0] err);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_inst"}, bus.out_inst, inst);
    check({tag, "_addr"}, bus.out_addr, addr);
    check({tag, "_err"}, {30'd0, bus.out_err}, {30'd0, err});
  endtask

  task automatic do_clr;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  function automatic logic [31:0] extract(input logic [2:0] fmt, input logic [31:0] i);
    case (fmt)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b011:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b001:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b010:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'd0};
    endcase
  endfunction

  initial begin
    logic [31:0] r, imm;
    logic [2:0]  f;
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    set_bundle(3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    send();
    expect_head("i_addi", 32'h0050_0093, 32'h0, 2'b00);

    do_clr();
    set_bundle(3'b001, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8);
    send();
    expect_head("b_neg8", 32'hFE20_8CE3, 32'h0, 2'b00);
    set_bundle(3'b010, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send();
    expect_head("j_2048", 32'h0010_00EF, 32'h4, 2'b00);

    do_clr();
    set_bundle(3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    send();
    expect_head("u_ok", 32'h1234_52B7, 32'h0, 2'b00);
    set_bundle(3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001);
    send();
    expect_head("u_misal", 32'h0000_0013, 32'h4, 2'b10);
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    send();
    expect_head("i_range", 32'h0000_0013, 32'h8, 2'b01);
    set_bundle(3'b111, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0);
    send();
    expect_head("fmt_ill", 32'h0000_0013, 32'hC, 2'b11);
    check("err_cnt3", {16'd0, err_cnt}, 32'd3);
    check("word_cnt4", {16'd0, word_cnt}, 32'd4);
    set_bundle(3'b001, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_2001);
    send();
    expect_head("b_misal_over_range", 32'h0000_0013, 32'h10, 2'b10);
    set_bundle(3'b010, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0010_0000);
    send();
    expect_head("j_range", 32'h0000_0013, 32'h14, 2'b01);
    set_bundle(3'b011, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'hFFFF_F800);
    send();
    expect_head("s_min", 32'h8020_A023, 32'h18, 2'b00);
    check("err_cnt5", {16'd0, err_cnt}, 32'd5);

    // Backpressure: two fit, the third waits until the head drains.
    do_clr();
    bus.out_ready = 1'b0;
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2);
    @(posedge clk); #1;
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3);
    check("bp_full_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_word_cnt", {16'd0, word_cnt}, 32'd2);
    expect_head("bp_hold0", 32'h0010_0093, 32'h0, 2'b00);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    expect_head("bp_pop1", 32'h0020_0093, 32'h4, 2'b00);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    expect_head("bp_third", 32'h0030_0093, 32'h8, 2'b00);
    @(posedge clk); #1;
    check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

    // clr with a full FIFO and a coincident valid bundle.
    bus.out_ready = 1'b0;
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd9);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0; bus.in_valid = 1'b0;
    check("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("clr_out_inst", bus.out_inst, 32'd0);
    check("clr_word_cnt", {16'd0, word_cnt}, 32'd0);
    bus.out_ready = 1'b1;
    set_bundle(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd7);
    send();
    expect_head("clr_base", 32'h0070_0093, 32'h0, 2'b00);

    for (int k = 0; k < 10000; k++) begin
      r = $urandom;
      f = 3'($urandom_range(0, 4));
      case (f)
        3'b000, 3'b011: imm = {{20{r[11]}}, r[11:0]};
        3'b001:         imm = {{19{r[12]}}, r[12:1], 1'b0};
        3'b010:         imm = {{11{r[20]}}, r[20:1], 1'b0};
        default:        imm = {r[31:12], 12'd0};
      endcase
      set_bundle(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
      send();
      check("rt_imm", extract(f, bus.out_inst), imm);
      check("rt_err", {30'd0, bus.out_err}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Packs decoded instruction fields and a 32-bit immediate into an RV32I instruction word. It is the inverse of the immediate extraction done in decode. The format code uses the same ExtOp encoding the decoder uses. The block sits in the debug/test program loader, ahead of instruction-memory writes, and emits the encoded word, a target address and an error code through a small output FIFO with a valid/ready handshake.

Parameters:
BASE_ADDR  32'h0000_0000  first write address after reset/clr
DEPTH      2              output FIFO entries (power of 2, >=2)
CNT_W      16             width of the saturating word/error counters

Ports:
clk        in   1      clock
rst        in   1      synchronous, active-high reset
clr        in   1      synchronous soft clear; same effect as rst
in_valid   in   1      input field bundle valid
in_ready   out  1      block can accept a bundle
in_fmt     in   3      000 I, 001 B, 010 J, 011 S, 100 U, 101 R, 110/111 illegal
in_opcode  in   7      opcode[6:0]
in_rd      in   5      rd
in_rs1     in   5      rs1
in_rs2     in   5      rs2
in_funct3  in   3      funct3
in_funct7  in   7      funct7 (R only)
in_imm     in   32     full sign-extended immediate (U: upper value, low 12 bits zero)
out_valid  out  1      FIFO head valid
out_ready  in   1      consumer accepts head
out_inst   out  32     encoded word
out_addr   out  32     write address for out_inst
out_err    out  2      00 ok, 01 range, 10 misaligned, 11 illegal fmt
word_cnt   out  CNT_W  bundles accepted, saturating
err_cnt    out  CNT_W  bundles accepted with out_err!=0, saturating

Behaviour:
- Reset/clr values:
  - FIFO empty; out_valid=0; out_inst=0, out_addr=0, out_err=0.
  - next_addr=BASE_ADDR; word_cnt=0; err_cnt=0.
  - in_ready=0 during the rst/clr cycle.
- A bundle is accepted when in_valid & in_ready. in_ready = !full & !rst & !clr. in_ready never depends on out_ready combinationally.
- Encoding per format:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; in_imm ignored.
- Error checks, priority illegal fmt > misaligned > range:
  - Misaligned: B or J with imm[0]=1; U with imm[11:0]!=0.
  - Range: I/S imm not a sign-extension of 12 bits; B not of 13 bits; J not of 21 bits.
- On error, the entry is still enqueued with out_inst=32'h0000_0013 (nop) and the error code. The address still advances and err_cnt increments.
- Round-trip property: for every legal I/S/B/J/U bundle, decode-side extraction of out_inst with in_fmt returns in_imm exactly.
- Address:
  - Captured into the entry as next_addr at accept.
  - next_addr += 4 per accept, wrapping modulo 2^32.
- Latency: an accepted bundle is visible at out_valid the next cycle (FIFO written at the edge, no combinational bypass).
- FIFO behaviour:
  - In-order; head popped when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - When full, in_ready=0, so no push is possible; a pop in that cycle raises in_ready next cycle.
  - out_* hold stable while out_valid & !out_ready.
- Counters: word_cnt increments per accept and holds at all-ones. err_cnt does the same, counting only errored accepts.
- clr/rst mid-operation:
  - Queued entries are discarded and a coincident in_valid is not accepted.
  - out_valid=0 the following cycle.
  - No partial entry survives.

Test Plan:
- I, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_inst 0x00500093, out_addr 0x0, err 00, one cycle after accept.
- B, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-8 -> 0xFE208CE3. Then J, opcode 1101111, rd=1, imm=2048 -> 0x001000EF, addr 0x4.
- U, opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7. U imm=0x12345001 -> err 10, inst 0x00000013. I imm=2048 -> err 01. fmt=111 -> err 11. err_cnt=3.
- out_ready=0, three back-to-back bundles -> two accepted, in_ready=0 after the second. Raise out_ready -> words drain in order at addr 0x0, 0x4, then the third is accepted at 0x8.
- FIFO holding 2 entries, assert clr with in_valid=1 -> nothing accepted, out_valid=0 next cycle, word_cnt=0, next accept gets BASE_ADDR.
- Random legal bundles with fmt 000–100, 10k iterations -> decode-side extraction of out_inst equals in_imm for every word; no errors.
